// File: rtl/dmem_lsu_ctrl_if.sv
// Bundle between the memory-stage request port, the LSU, and the word-wide data memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the
// requester holds every req_* field stable until then. resp_valid is a one-cycle pulse
// that cannot be stalled, and resp_rdata/resp_err are meaningful only while it is high.
interface dmem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // Core plus memory side.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_en, mem_addr, mem_write_data
  );

  // The load/store sequencer.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Byte/half/word load-store sequencer onto a word-wide data memory (read-modify-write
// for sub-word stores). Optional macro DMEM_LSU_MISALIGN_CHECK_EN flags misaligned accesses.
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  dmem_lsu_ctrl_if.slave  bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [1:0]  cap_lane;
  logic [31:0] cap_wdata;
  logic        err_q;
  logic        misaligned;
  logic [31:0] word_idx;
  logic        unused_addr_hi;

  assign bus.req_ready = (state == IDLE);
  assign bus.resp_err  = err_q;
  assign dbg_state     = state;

  // Upper address bits alias onto the memory; they are dropped rather than flagged.
  assign word_idx       = 32'(bus.req_addr[ADDR_W+1:2]);
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_LSU_MISALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Halves look only at lane[1] and words ignore the lane, which silently aligns
  // any low address bits that the misalignment check does not catch.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    case (size)
      2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    merge = m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cap_we             <= 1'b0;
      cap_size           <= 2'b00;
      cap_uns            <= 1'b0;
      cap_lane           <= 2'b00;
      cap_wdata          <= 32'd0;
      err_q              <= 1'b0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= 32'd0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_addr       <= 32'd0;
      bus.mem_write_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid <= 1'b0;
          if (bus.req_valid) begin
            cap_we       <= bus.req_we;
            cap_size     <= bus.req_size;
            cap_uns      <= bus.req_unsigned;
            cap_lane     <= bus.req_addr[1:0];
            cap_wdata    <= bus.req_wdata;
            bus.mem_addr <= word_idx;
            if (misaligned) begin
              // Rejected without touching memory; response goes out next cycle.
              err_q          <= 1'b1;
              bus.resp_rdata <= 32'd0;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else if (bus.req_we && bus.req_size[1]) begin
              bus.mem_write_data <= bus.req_wdata;
              bus.mem_write_en   <= 1'b1;
              state              <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (cap_we) begin
            bus.mem_write_data <= merge(bus.mem_read_data, cap_wdata, cap_size, cap_lane);
            bus.mem_write_en   <= 1'b1;
            state              <= WR;
          end else begin
            bus.resp_rdata <= extract(bus.mem_read_data, cap_size, cap_uns, cap_lane);
            err_q          <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WR: begin
          bus.mem_write_en <= 1'b0;
          bus.resp_rdata   <= 32'd0;
          err_q            <= 1'b0;
          bus.resp_valid   <= 1'b1;
          state            <= RESP;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store sequencer between the core's memory stage and the word-wide data memory. It accepts byte/halfword/word load and store requests on a valid/ready handshake and converts them into word accesses. Loads get lane extraction and sign/zero extension. Sub-word stores are done as read-modify-write. It drives the data memory's write_en/addr/write_data and samples read_data; the memory updates on the falling clock edge, and this block runs on the rising edge.

## Interface
Parameters:
- ADDR_W, 12, word-index bits forwarded to memory (4096 words)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misalignment flag, qualified by resp_valid
- mem_write_en  out  1  to memory write_en
- mem_addr  out  32  word index, zero-extended: {0, req_addr[ADDR_W+1:2]}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  from memory read_data

## Operation
- FSM states: IDLE, RD, WR, RESP. All outputs are registered, except req_ready = (state==IDLE).
- IDLE, handshake (req_valid && req_ready at a rising edge):
  - Capture all req_* fields.
  - Misaligned (only with macro): go to RESP.
  - Word store: go to WR.
  - Otherwise: go to RD.
- RD:
  - mem_addr is valid and mem_write_en=0.
  - The memory samples on the falling edge. mem_read_data is valid at the next rising edge.
  - On that edge, a load latches the extracted value into resp_rdata and goes to RESP.
  - On that edge, a sub-word store latches the merged word into mem_write_data and goes to WR.
- WR:
  - mem_write_en=1 for exactly one cycle.
  - The memory writes on the falling edge.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - The response is not back-pressured.
  - Next state is IDLE.
- Lanes are little-endian: byte k = word[8k+7:8k].
  - Byte lane = req_addr[1:0].
  - Half lane = req_addr[1] (bits [15:0] or [31:16]).
- Load extension: bit 7 or bit 15 replicated upward unless req_unsigned. Word loads pass through unchanged.
- Store merge: replace only the addressed lane(s) of the read word. All other bits keep their read values.
- Address bits above ADDR_W+1 are ignored and not flagged.
- Requests are not accepted during RD, WR or RESP. Upstream holds req_* until accepted.

## Timing
Handshake at rising edge N:
- Load: RD in cycle N..N+1; resp_valid high in cycle N+1..N+2; resp_rdata valid with it.
- Word store: WR in cycle N..N+1 (memory written at that falling edge); resp_valid in cycle N+1..N+2.
- Sub-word store: RD in N..N+1, WR in N+1..N+2, resp_valid in N+2..N+3.
- Next acceptance: earliest at edge N+3 after a load or word store, and at edge N+4 after a sub-word store.

Reset values:
- state=IDLE, so req_ready=1 once rst deasserts.
- resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0, mem_addr=0, mem_write_data=0.

Reset mid-operation:
- Any in-flight request is dropped and no resp_valid is produced.
- mem_write_en clears asynchronously, so a write whose falling edge falls inside reset is suppressed.

## Configuration
DMEM_LSU_MISALIGN_CHECK_EN:
- Defined:
  - A half with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE→RESP with resp_err=1 and resp_rdata=0.
  - No memory access occurs; mem_write_en stays 0.
  - resp_valid appears in cycle N..N+1.
- Undefined:
  - Low address bits are forced to alignment: halves use addr[1] only, words ignore addr[1:0].
  - resp_err is tied 0.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load 0x100 → resp_rdata=0xDEADBEEF; store response 2 edges after acceptance; mem_write_en high exactly 1 cycle.
- Preload 0x100=0x11223344; sb 0xAA to 0x102 → memory word 0x11AA3344; lb 0x102 signed → 0xFFFFFFAA; lbu 0x102 → 0x000000AA.
- Preload 0x200=0x80017FFF; lh 0x202 → 0xFFFF8001; lhu 0x200 → 0x00007FFF; sh 0x1234 to 0x200 → word 0x80011234.
- Macro defined: lw 0x101 → resp_err=1, resp_rdata=0, mem_write_en never high. Macro undefined: same request → data of word 0x100, resp_err=0.
- Assert rst while a sub-word store is in RD → no write to memory, no resp_valid; after release req_ready=1 and all outputs 0.
- Hold req_valid with back-to-back lw requests → req_ready low in RD/RESP; each response is followed by exactly one acceptance, with no lost or duplicated requests.
